// File: rtl/sparsity_mask_pkg.sv
// Shared definitions for the sparsity mask unit.
//   state_t   : transaction FSM encoding (2'b11 is unused/illegal)
//   LENGTH    : default mask width
//   popcount  : population count, used only when MASK_POPCOUNT_EN is defined
package sparsity_mask_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } state_t;

  localparam int LENGTH = 32;

  // Widest mask the popcount helper accepts; narrower masks are zero-extended.
  localparam int POP_MAX_W = 1024;

  function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int k = 0; k < POP_MAX_W; k++) begin
      n = n + {31'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sparsity_mask_combine.sv
// mask_combine: purely combinational split of two nonzero masks.
//   a, b    : input masks (1 = nonzero)
//   both    : a & b        (effectual pairs)
//   a_only  : both ^ a     (= a & ~b)
//   b_only  : both ^ b     (= b & ~a)
// Every bit is independent; the three outputs are pairwise disjoint and
// their union equals a | b.
module mask_combine #(
  parameter int length = 32
) (
  input  logic [length-1:0] a,
  input  logic [length-1:0] b,
  output logic [length-1:0] both,
  output logic [length-1:0] a_only,
  output logic [length-1:0] b_only
);

  assign both   = a & b;
  assign a_only = both ^ a;
  assign b_only = both ^ b;

endmodule

// File: rtl/sparsity_mask.sv
// sparsity_mask: captures an activation and a weight nonzero mask, then
// produces registered effectual-pair and residue masks under a
// ready/taken handshake.
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   i_mask/w_mask : activation / weight nonzero masks
//   input_ready   : start pulse, honoured only in IDLE
//   output_taken  : result acknowledge, honoured only in DONE
//   o_mask        : i & w
//   xor_i_mask    : i & ~w
//   xor_w_mask    : w & ~i
//   state         : current FSM state (IDLE / COMPUTE / DONE)
//   o_count       : popcount of o_mask, present only with MASK_POPCOUNT_EN
// Results appear with state == DONE, two edges after input_ready is
// sampled, and hold until the next COMPUTE.
module sparsity_mask
  import sparsity_mask_pkg::*;
#(
  parameter int length = LENGTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [length-1:0] i_mask,
  input  logic [length-1:0] w_mask,
  input  logic              input_ready,
  input  logic              output_taken,
  output logic [length-1:0] o_mask,
  output logic [length-1:0] xor_i_mask,
  output logic [length-1:0] xor_w_mask,
  output logic [1:0]        state
`ifdef MASK_POPCOUNT_EN
  ,
  output logic [$clog2(length+1)-1:0] o_count
`endif
);

  state_t            state_q, state_d;
  logic              capture, compute;
  logic [length-1:0] i_mask_p0, w_mask_p0;
  logic [length-1:0] and_c, xor_i_c, xor_w_c;

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Comparing against a literal 1 keeps X/Z on the handshakes from
  // starting or closing a transaction in simulation.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    compute = 1'b0;
    case (state_q)
      IDLE: begin
        if (input_ready == 1'b1) begin
          capture = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        compute = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (output_taken == 1'b1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: captured operand masks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_mask_p0 <= '0;
      w_mask_p0 <= '0;
    end else if (capture) begin
      i_mask_p0 <= i_mask;
      w_mask_p0 <= w_mask;
    end
  end

  mask_combine #(.length(length)) u_combine (
    .a      (i_mask_p0),
    .b      (w_mask_p0),
    .both   (and_c),
    .a_only (xor_i_c),
    .b_only (xor_w_c)
  );

  // Stage p1: result masks, written only in COMPUTE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_mask     <= '0;
      xor_i_mask <= '0;
      xor_w_mask <= '0;
    end else if (compute) begin
      o_mask     <= and_c;
      xor_i_mask <= xor_i_c;
      xor_w_mask <= xor_w_c;
    end
  end

`ifdef MASK_POPCOUNT_EN
  localparam int CW = $clog2(length+1);

  logic [POP_MAX_W-1:0] and_ext;

  assign and_ext = POP_MAX_W'(and_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        o_count <= '0;
    else if (compute) o_count <= CW'(popcount(and_ext));
  end
`endif

endmodule

// File: tb/tb_sparsity_mask.sv
// Testbench for sparsity_mask: randomized and directed transactions with a
// queue-based scoreboard. The stimulus process pushes the expected result
// of every started transaction; a monitor pops it when the DUT enters DONE
// and checks the outputs on every cycle thereafter (they must hold).
module tb_sparsity_mask;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] xi;
    logic [W-1:0] xw;
    logic [31:0]  cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] i_mask, w_mask;
  logic         input_ready, output_taken;
  logic [W-1:0] o_mask, xor_i_mask, xor_w_mask;
  logic [1:0]   state;
`ifdef MASK_POPCOUNT_EN
  logic [$clog2(W+1)-1:0] o_count;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic [1:0] prev;

  sparsity_mask #(.length(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mask       (i_mask),
    .w_mask       (w_mask),
    .input_ready  (input_ready),
    .output_taken (output_taken),
    .o_mask       (o_mask),
    .xor_i_mask   (xor_i_mask),
    .xor_w_mask   (xor_w_mask),
    .state        (state)
`ifdef MASK_POPCOUNT_EN
    ,
    .o_count      (o_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: classify each bit position from the operand rules.
  function automatic exp_t model(input logic [W-1:0] i, input logic [W-1:0] w);
    exp_t r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      if (i[k] && w[k]) begin
        r.o[k] = 1'b1;
        r.cnt  = r.cnt + 1;
      end else if (i[k]) begin
        r.xi[k] = 1'b1;
      end else if (w[k]) begin
        r.xw[k] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_outputs(input exp_t e);
    chk("o_mask", 64'(o_mask), 64'(e.o));
    chk("xor_i_mask", 64'(xor_i_mask), 64'(e.xi));
    chk("xor_w_mask", 64'(xor_w_mask), 64'(e.xw));
`ifdef MASK_POPCOUNT_EN
    chk("o_count", 64'(o_count), 64'(e.cnt));
`endif
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      cur  = '0;
      prev = 2'b00;
    end else begin
      if (state == 2'b10 && prev != 2'b10) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty actual=DONE required=no_transaction t=%0t", $time);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      chk_outputs(cur);
      prev = state;
    end
  end

  task automatic txn(input logic [W-1:0] i, input logic [W-1:0] w,
                     input bit spur, input int hold);
    @(negedge clk);
    i_mask      = i;
    w_mask      = w;
    input_ready = 1'b1;
    exp_q.push_back(model(i, w));
    @(negedge clk);
    chk("state_compute", 64'(state), 64'(2'b01));
    input_ready  = spur;
    output_taken = spur;
    if (spur) begin
      i_mask = $urandom;
      w_mask = $urandom;
    end
    @(negedge clk);
    chk("state_done", 64'(state), 64'(2'b10));
    output_taken = 1'b0;
    repeat (hold) begin
      input_ready = 1'($urandom_range(0, 1));
      i_mask      = $urandom;
      w_mask      = $urandom;
      @(negedge clk);
      chk("state_hold", 64'(state), 64'(2'b10));
    end
    input_ready  = 1'b0;
    output_taken = 1'b1;
    @(negedge clk);
    output_taken = spur;
    chk("state_idle", 64'(state), 64'(2'b00));
    @(negedge clk);
    output_taken = 1'b0;
    chk("state_idle_stray_ack", 64'(state), 64'(2'b00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    i_mask       = '0;
    w_mask       = '0;
    input_ready  = 1'b0;
    output_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'(state), 64'(2'b00));

    // Directed transactions
    txn(32'hD3D3D3D3, 32'hB9B89332, 1'b0, 12);
    txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3);
    txn(32'hAAAAAAAA, 32'h55555555, 1'b1, 2);

    // Asynchronous reset while in COMPUTE
    @(negedge clk);
    i_mask      = $urandom;
    w_mask      = $urandom;
    input_ready = 1'b1;
    @(posedge clk);
    #1 input_ready = 1'b0;
    chk("state_pre_reset", 64'(state), 64'(2'b01));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", 64'(state), 64'(2'b00));
    chk("async_reset_o_mask", 64'(o_mask), 64'(0));
    chk("async_reset_xor_i", 64'(xor_i_mask), 64'(0));
    chk("async_reset_xor_w", 64'(xor_w_mask), 64'(0));
`ifdef MASK_POPCOUNT_EN
    chk("async_reset_count", 64'(o_count), 64'(0));
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("state_after_reset", 64'(state), 64'(2'b00));

    // Randomized transactions, with some denser / sparser mask mixes
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: a = a & $urandom;
        1: b = b | $urandom;
        2: b = ~a ^ (a & $urandom);
        default: ;
      endcase
      txn(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
